// File: rtl/fx2_slave_fifo_model_if.sv
// FX2 slave-FIFO pin bundle plus the host-side EP2/EP6 streams.
// The master modport is the environment (FPGA + host); the slave modport is the FX2 model.
interface fx2_slave_fifo_model_if;
    logic [15:0] fx2_fd_in;
    logic [15:0] fx2_fd_out;
    logic        fx2_fd_oe;
    logic        fx2_sloe;
    logic        fx2_slrd;
    logic        fx2_slwr;
    logic        fx2_pktend;
    logic [1:0]  fx2_fifoadr;
    logic        fx2_flaga;
    logic        fx2_flagb;
    logic        fx2_flagc;
    logic        fx2_flagd;
    logic [15:0] h2d_data;
    logic        h2d_valid;
    logic        h2d_ready;
    logic [15:0] d2h_data;
    logic        d2h_last;
    logic        d2h_valid;
    logic        d2h_ready;
    logic        err_overflow;
    logic        err_underflow;

    modport master (
        output fx2_fd_in, fx2_sloe, fx2_slrd, fx2_slwr, fx2_pktend, fx2_fifoadr,
        output h2d_data, h2d_valid, d2h_ready,
        input  fx2_fd_out, fx2_fd_oe, fx2_flaga, fx2_flagb, fx2_flagc, fx2_flagd,
        input  h2d_ready, d2h_data, d2h_last, d2h_valid, err_overflow, err_underflow
    );

    modport slave (
        input  fx2_fd_in, fx2_sloe, fx2_slrd, fx2_slwr, fx2_pktend, fx2_fifoadr,
        input  h2d_data, h2d_valid, d2h_ready,
        output fx2_fd_out, fx2_fd_oe, fx2_flaga, fx2_flagb, fx2_flagc, fx2_flagd,
        output h2d_ready, d2h_data, d2h_last, d2h_valid, err_overflow, err_underflow
    );
endinterface

// File: rtl/fx2_slave_fifo_model.sv
// Behavioural FX2 slave-FIFO: EP2 (host->FPGA) FWFT FIFO and EP6 (FPGA->host) FIFO with
// packet auto-commit / PKTEND, so the host side only ever sees committed packets.
module fx2_slave_fifo_model #(
    parameter int unsigned EP2_DEPTH = 512,
    parameter int unsigned EP6_DEPTH = 512,
    parameter int unsigned PKT_WORDS = 256,
    parameter int unsigned AF_MARGIN = 4
) (
    input logic                  clk,
    input logic                  rst,
    fx2_slave_fifo_model_if.slave bus
);
    localparam int unsigned A2W = $clog2(EP2_DEPTH);
    localparam int unsigned A6W = $clog2(EP6_DEPTH);
    localparam int unsigned UW  = $clog2(PKT_WORDS + 1);

    // ---------------- EP2 ----------------
    logic [15:0]    r_ep2_mem [EP2_DEPTH];
    logic [A2W-1:0] r_ep2_wr, r_ep2_rd;
    logic [A2W:0]   r_ep2_cnt;
    logic           r_err_underflow;

    logic w_ep2_sel, w_ep2_empty, w_ep2_full, w_ep2_push, w_ep2_rd_req, w_ep2_pop;
    assign w_ep2_sel    = (bus.fx2_fifoadr == 2'b00);
    assign w_ep2_empty  = (r_ep2_cnt == '0);
    assign w_ep2_full   = (r_ep2_cnt == (A2W+1)'(EP2_DEPTH));
    assign w_ep2_push   = bus.h2d_valid && !w_ep2_full;
    assign w_ep2_rd_req = !bus.fx2_slrd && w_ep2_sel;
    assign w_ep2_pop    = w_ep2_rd_req && !w_ep2_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ep2_wr        <= '0;
            r_ep2_rd        <= '0;
            r_ep2_cnt       <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_ep2_push) r_ep2_wr <= r_ep2_wr + A2W'(1);
            if (w_ep2_pop)  r_ep2_rd <= r_ep2_rd + A2W'(1);
            if (w_ep2_push && !w_ep2_pop)      r_ep2_cnt <= r_ep2_cnt + (A2W+1)'(1);
            else if (!w_ep2_push && w_ep2_pop) r_ep2_cnt <= r_ep2_cnt - (A2W+1)'(1);
            if (w_ep2_rd_req && w_ep2_empty) r_err_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_ep2_push) r_ep2_mem[r_ep2_wr] <= bus.h2d_data;
    end

    // ---------------- EP6 ----------------
    logic [15:0]          r_ep6_mem [EP6_DEPTH];
    logic [EP6_DEPTH-1:0] r_ep6_last;
    logic [A6W-1:0]       r_ep6_wr, r_ep6_rd;
    logic [A6W:0]         r_ep6_cnt, r_ep6_cmt;
    logic [UW-1:0]        r_ep6_unc;
    logic                 r_err_overflow;

    logic w_ep6_sel, w_ep6_full, w_ep6_wr_req, w_ep6_write, w_pktend;
    logic w_commit, w_mark_old, w_d2h_valid, w_d2h_pop;
    logic [UW-1:0] w_unc_inc;
    logic [A6W:0]  w_commit_n;

    assign w_ep6_sel    = (bus.fx2_fifoadr == 2'b10);
    assign w_ep6_full   = (r_ep6_cnt == (A6W+1)'(EP6_DEPTH));
    assign w_ep6_wr_req = !bus.fx2_slwr && w_ep6_sel;
    assign w_ep6_write  = w_ep6_wr_req && !w_ep6_full;
    assign w_pktend     = !bus.fx2_pktend && w_ep6_sel;
    assign w_unc_inc    = r_ep6_unc + UW'(w_ep6_write);
    // A write commits on reaching a full packet or alongside PKTEND; a bare PKTEND needs U>0.
    assign w_commit     = w_ep6_write ? (w_unc_inc == UW'(PKT_WORDS) || w_pktend)
                                      : (w_pktend && r_ep6_unc != '0);
    assign w_mark_old   = w_pktend && !w_ep6_write && (r_ep6_unc != '0);
    assign w_commit_n   = w_commit ? (A6W+1)'(w_unc_inc) : '0;
    assign w_d2h_valid  = (r_ep6_cmt != '0);
    assign w_d2h_pop    = w_d2h_valid && bus.d2h_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ep6_wr       <= '0;
            r_ep6_rd       <= '0;
            r_ep6_cnt      <= '0;
            r_ep6_cmt      <= '0;
            r_ep6_unc      <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_ep6_write) r_ep6_wr <= r_ep6_wr + A6W'(1);
            if (w_d2h_pop)   r_ep6_rd <= r_ep6_rd + A6W'(1);
            if (w_ep6_write && !w_d2h_pop)      r_ep6_cnt <= r_ep6_cnt + (A6W+1)'(1);
            else if (!w_ep6_write && w_d2h_pop) r_ep6_cnt <= r_ep6_cnt - (A6W+1)'(1);
            r_ep6_cmt <= r_ep6_cmt + w_commit_n - (A6W+1)'(w_d2h_pop);
            r_ep6_unc <= w_commit ? '0 : w_unc_inc;
            if (w_ep6_wr_req && w_ep6_full) r_err_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_ep6_write) begin
            r_ep6_mem[r_ep6_wr]  <= bus.fx2_fd_in;
            r_ep6_last[r_ep6_wr] <= w_commit;
        end else if (!rst && w_mark_old) begin
            r_ep6_last[r_ep6_wr - A6W'(1)] <= 1'b1;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.fx2_fd_out    = w_ep2_empty ? 16'h0 : r_ep2_mem[r_ep2_rd];
        bus.fx2_fd_oe     = !bus.fx2_sloe && w_ep2_sel;
        bus.h2d_ready     = !w_ep2_full;
        bus.d2h_valid     = w_d2h_valid;
        bus.d2h_data      = w_d2h_valid ? r_ep6_mem[r_ep6_rd] : 16'h0;
        bus.d2h_last      = w_d2h_valid && r_ep6_last[r_ep6_rd];
        bus.fx2_flaga     = !w_ep2_empty;
        bus.fx2_flagb     = !w_ep6_full;
        bus.fx2_flagc     = ((A6W+1)'(EP6_DEPTH) - r_ep6_cnt) > (A6W+1)'(AF_MARGIN);
        bus.fx2_flagd     = (r_ep6_cnt == '0);
        bus.err_overflow  = r_err_overflow;
        bus.err_underflow = r_err_underflow;
    end
endmodule
